// File: rtl/iopmp_err_capture.sv
// IOPMP error capture: sticky first-violation record, overflow flag, irq.
// Optional saturating violation counter is compiled in with IOPMP_ERR_CNT_EN.
package iopmp_pkg;
  typedef enum logic [1:0] {
    IOPMP_ACCESS_NONE  = 2'd0,
    IOPMP_ACCESS_READ  = 2'd1,
    IOPMP_ACCESS_WRITE = 2'd2,
    IOPMP_ACCESS_EXEC  = 2'd3
  } iopmp_req_e;
endpackage

module iopmp_err_capture
  import iopmp_pkg::*;
#(
  parameter int unsigned IOPMPNumChan = 2,
  parameter int unsigned ErrCntWidth  = 16,
  localparam int unsigned CW =
    (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IOPMPNumChan-1:0] req_valid_i,
  input  logic [IOPMPNumChan-1:0] iopmp_req_err_i,
  input  logic [33:0]             iopmp_req_addr_i [IOPMPNumChan],
  input  iopmp_req_e              iopmp_req_type_i [IOPMPNumChan],
  input  logic [7:0]              entry_violated_index_i [IOPMPNumChan],
  input  logic                    irq_en_i,
  input  logic                    err_clr_i,
  output logic                    err_valid_o,
  output logic [CW-1:0]           err_chan_o,
  output logic [33:0]             err_addr_o,
  output iopmp_req_e              err_type_o,
  output logic [7:0]              err_eid_o,
  output logic                    err_ovf_o,
  output logic                    irq_o
`ifdef IOPMP_ERR_CNT_EN
  ,
  output logic [ErrCntWidth-1:0]  err_cnt_o
`endif
);

  localparam int unsigned NW = $clog2(IOPMPNumChan + 1);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [IOPMPNumChan-1:0] fault;
  logic                    any_fault;
  logic                    multi;
  logic [NW-1:0]           nfault;
  logic [CW-1:0]           win_chan;
  logic [33:0]             win_addr;
  iopmp_req_e              win_type;
  logic [7:0]              win_eid;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [33:0]   addr_q, addr_d;
  iopmp_req_e    type_q, type_d;
  logic [7:0]    eid_q, eid_d;
  logic          ovf_q, ovf_d;

  assign fault     = req_valid_i & iopmp_req_err_i;
  assign any_fault = |fault;
  assign multi     = nfault > NW'(1);

  // Descending scan so the lowest faulting channel is the last writer.
  always_comb begin
    nfault   = '0;
    win_chan = '0;
    win_addr = '0;
    win_type = IOPMP_ACCESS_NONE;
    win_eid  = '0;
    for (int c = int'(IOPMPNumChan) - 1; c >= 0; c--) begin
      nfault = nfault + NW'(fault[c]);
      if (fault[c]) begin
        win_chan = CW'(unsigned'(c));
        win_addr = iopmp_req_addr_i[c];
        win_type = iopmp_req_type_i[c];
        win_eid  = entry_violated_index_i[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    type_d  = type_q;
    eid_d   = eid_q;
    ovf_d   = ovf_q;
    if (any_fault && (state_q == EMPTY || err_clr_i)) begin
      state_d = FULL;
      chan_d  = win_chan;
      addr_d  = win_addr;
      type_d  = win_type;
      eid_d   = win_eid;
      ovf_d   = multi;
    end else if (any_fault) begin
      ovf_d = 1'b1;
    end else if (err_clr_i) begin
      state_d = EMPTY;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      chan_q  <= '0;
      addr_q  <= '0;
      type_q  <= IOPMP_ACCESS_NONE;
      eid_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      eid_q   <= eid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign err_valid_o = (state_q == FULL);
  assign err_chan_o  = chan_q;
  assign err_addr_o  = addr_q;
  assign err_type_o  = type_q;
  assign err_eid_o   = eid_q;
  assign err_ovf_o   = ovf_q;
  assign irq_o       = err_valid_o & irq_en_i;

`ifdef IOPMP_ERR_CNT_EN
  localparam int unsigned SW = ErrCntWidth + NW;

  logic [ErrCntWidth-1:0] cnt_q, cnt_d;
  logic [SW-1:0]          cnt_sum;

  assign cnt_sum = SW'(cnt_q) + SW'(nfault);
  assign cnt_d   = (cnt_sum > SW'({ErrCntWidth{1'b1}})) ?
                   {ErrCntWidth{1'b1}} : cnt_sum[ErrCntWidth-1:0];

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_iopmp_err_capture.sv
// Self-checking bench for iopmp_err_capture: directed steps then random traffic
// against a behavioural record model; honours IOPMP_ERR_CNT_EN.
module tb_iopmp_err_capture;
  import iopmp_pkg::*;

  localparam int N    = 3;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     v, e;
  logic [33:0]      addr [N];
  iopmp_req_e       typ  [N];
  logic [7:0]       eid  [N];
  logic             irq_en, clr;
  logic             o_valid, o_ovf, o_irq;
  logic [1:0]       o_chan;
  logic [33:0]      o_addr;
  iopmp_req_e       o_type;
  logic [7:0]       o_eid;
  logic [CNTW-1:0]  o_cnt;

  int total = 0;
  int bad   = 0;

  // reference state
  bit          m_valid, m_ovf;
  int          m_chan, m_cnt;
  logic [33:0] m_addr;
  logic [1:0]  m_type;
  logic [7:0]  m_eid;

  always #5 clk = ~clk;

  iopmp_err_capture #(
    .IOPMPNumChan(N),
    .ErrCntWidth (CNTW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid_i           (v),
    .iopmp_req_err_i       (e),
    .iopmp_req_addr_i      (addr),
    .iopmp_req_type_i      (typ),
    .entry_violated_index_i(eid),
    .irq_en_i              (irq_en),
    .err_clr_i             (clr),
    .err_valid_o           (o_valid),
    .err_chan_o            (o_chan),
    .err_addr_o            (o_addr),
    .err_type_o            (o_type),
    .err_eid_o             (o_eid),
    .err_ovf_o             (o_ovf),
    .irq_o                 (o_irq)
`ifdef IOPMP_ERR_CNT_EN
    ,
    .err_cnt_o             (o_cnt)
`endif
  );

`ifndef IOPMP_ERR_CNT_EN
  assign o_cnt = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    v   = '0;
    e   = '0;
    clr = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < N; c++) begin
      addr[c] = '0;
      typ[c]  = IOPMP_ACCESS_NONE;
      eid[c]  = '0;
    end
  endtask

  task automatic fault_on(input int c, input logic [33:0] a,
                          input iopmp_req_e t, input logic [7:0] x);
    v[c]    = 1'b1;
    e[c]    = 1'b1;
    addr[c] = a;
    typ[c]  = t;
    eid[c]  = x;
  endtask

  task automatic model_step();
    int q[$];
    for (int c = 0; c < N; c++)
      if (v[c] && e[c]) q.push_back(c);
    if (rst) begin
      m_valid = 0; m_ovf = 0; m_chan = 0; m_cnt = 0;
      m_addr = '0; m_type = '0; m_eid = '0;
    end else begin
      m_cnt = (m_cnt + q.size() > CMAX) ? CMAX : m_cnt + q.size();
      if (q.size() > 0 && (!m_valid || clr)) begin
        m_valid = 1;
        m_chan  = q[0];
        m_addr  = addr[q[0]];
        m_type  = typ[q[0]];
        m_eid   = eid[q[0]];
        m_ovf   = q.size() > 1;
      end else if (q.size() > 0) begin
        m_ovf = 1;
      end else if (clr) begin
        m_valid = 0;
        m_ovf   = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(o_valid), 64'(m_valid));
    chk("ovf",   64'(o_ovf),   64'(m_ovf));
    chk("irq",   64'(o_irq),   64'(m_valid && irq_en));
    chk("chan",  64'(o_chan),  64'(m_chan));
    chk("addr",  64'(o_addr),  64'(m_addr));
    chk("type",  64'(o_type),  64'(m_type));
    chk("eid",   64'(o_eid),   64'(m_eid));
`ifdef IOPMP_ERR_CNT_EN
    chk("cnt",   64'(o_cnt),   64'(m_cnt));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    irq_en = 1'b0;
    idle_inputs();
    m_valid = 0; m_ovf = 0; m_chan = 0; m_cnt = 0;
    m_addr = '0; m_type = '0; m_eid = '0;

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("idle_valid", 64'(o_valid), 64'd0);
    chk("idle_irq",   64'(o_irq),   64'd0);

    // single fault on channel 1
    irq_en = 1'b1;
    fault_on(1, 34'h0_8000_1000, IOPMP_ACCESS_READ, 8'd5);
    cycle();
    idle_inputs();
    chk("cap_valid", 64'(o_valid), 64'd1);
    chk("cap_chan",  64'(o_chan),  64'd1);
    chk("cap_addr",  64'(o_addr),  64'h0_8000_1000);
    chk("cap_eid",   64'(o_eid),   64'd5);
    chk("cap_irq",   64'(o_irq),   64'd1);
    cycle();

    // two channels at once from a fresh reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    fault_on(0, 34'h1_0000_0040, IOPMP_ACCESS_WRITE, 8'd9);
    fault_on(1, 34'h0_0000_3000, IOPMP_ACCESS_READ, 8'd2);
    cycle();
    idle_inputs();
    chk("dual_chan", 64'(o_chan), 64'd0);
    chk("dual_ovf",  64'(o_ovf),  64'd1);
`ifdef IOPMP_ERR_CNT_EN
    chk("dual_cnt",  64'(o_cnt),  64'd2);
`endif

    // full record ignores new fault, then clear + reload
    clr = 1'b1;
    cycle();
    idle_inputs();
    fault_on(2, 34'h2_0000_0100, IOPMP_ACCESS_EXEC, 8'd7);
    cycle();
    idle_inputs();
    chk("full_ovf0", 64'(o_ovf), 64'd0);
    fault_on(0, 34'h0_0000_2000, IOPMP_ACCESS_WRITE, 8'd1);
    cycle();
    idle_inputs();
    chk("frozen_addr", 64'(o_addr), 64'h2_0000_0100);
    chk("frozen_ovf",  64'(o_ovf),  64'd1);
    clr = 1'b1;
    fault_on(1, 34'h0_0000_4000, IOPMP_ACCESS_READ, 8'd3);
    cycle();
    idle_inputs();
    chk("reload_chan",  64'(o_chan),  64'd1);
    chk("reload_ovf",   64'(o_ovf),   64'd0);
    chk("reload_valid", 64'(o_valid), 64'd1);

    // irq masking then clear
    irq_en = 1'b0;
    cycle();
    chk("mask_irq", 64'(o_irq), 64'd0);
    irq_en = 1'b1;
    cycle();
    chk("unmask_irq", 64'(o_irq), 64'd1);
    clr = 1'b1;
    cycle();
    idle_inputs();
    chk("clr_valid", 64'(o_valid), 64'd0);
    chk("clr_irq",   64'(o_irq),   64'd0);

    // counter saturation
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fault_on(2, 34'(i), IOPMP_ACCESS_READ, 8'(i));
      clr = i[0];
      cycle();
    end
    idle_inputs();
`ifdef IOPMP_ERR_CNT_EN
    chk("sat_cnt", 64'(o_cnt), 64'(CMAX));
`endif

    // reset together with a fault
    fault_on(0, 34'h3_FFFF_FFFF, IOPMP_ACCESS_EXEC, 8'hFF);
    rst = 1'b1;
    cycle();
    idle_inputs();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_addr",  64'(o_addr),  64'd0);
    chk("rst_ovf",   64'(o_ovf),   64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        v[c]    = ($urandom_range(0, 2) != 0);
        e[c]    = ($urandom_range(0, 3) == 0);
        addr[c] = {$urandom_range(0, 3), $urandom()};
        typ[c]  = iopmp_req_e'($urandom_range(0, 3));
        eid[c]  = 8'($urandom());
      end
      clr    = ($urandom_range(0, 3) == 0);
      irq_en = ($urandom_range(0, 4) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
